ins_cache_r32i: RTL and testbench
=================================

// Module: ins_cache_r32i
// PURPOSE
//  Direct-mapped, read-only instruction cache that sits directly downstream of the RV32I PC.
//  Looks up ProgAddr and returns the instruction word.
//  On a miss it raises InsCacheStall, which holds the PC, and refills one line from instruction
//  memory over a req/ack word interface.
// PARAMETERS
//  dataW     32  address / instruction width
//  LINES     8   number of cache lines (power of 2, >=2)
//  WORDS     4   32-bit words per line (power of 2, >=2)
// PORTS
//  clock          in   1      system clock, all state on posedge
//  reset          in   1      synchronous, active-high
//  ProgAddr       in   dataW  fetch address from PC
//  Flush          in   1      invalidate all lines (e.g. fence.i)
//  Instruction    out  dataW  instruction at ProgAddr; valid when InsCacheStall=0
//  InsCacheStall  out  1      high: Instruction is not valid, PC must hold
//  MemReq         out  1      refill word request to instruction memory
//  MemAddr        out  dataW  word-aligned refill address
//  MemAck         in   1      memory has returned MemData for the current MemAddr
//  MemData        in   dataW  refill data word
// BEHAVIOUR
//  Address split: [1:0] ignored; word = [W+1:2]; index = next L bits; tag = the remaining upper bits.
//  W = $clog2(WORDS) and L = $clog2(LINES).
//  Lookup is combinational: hit = valid[index] && tag_q[index]==tag && state==IDLE.
//  On a hit, Instruction = data[index][word] and InsCacheStall = 0 in the same cycle.
//  InsCacheStall = !hit || reset || Flush. On a miss, Instruction drives 0.
//  FSM states are IDLE, FILL and FLUSHED:
//   IDLE: on a miss (and no Flush), latch FillBase = {ProgAddr[31:W+2], W+2'b0}.
//     Also clear valid[index], set cnt = 0 and go to FILL.
//   FILL: MemReq = 1 and MemAddr = FillBase + 4*cnt.
//     On MemAck, write MemData to data[index][cnt] and increment cnt.
//     On the last word (cnt == WORDS-1 with MemAck), set valid[index] and tag_q[index], then go to IDLE.
//     The hit is visible on the cycle after the last MemAck, so miss latency = WORDS ack beats + 1.
//     MemReq and MemAddr hold stable until MemAck; there are no back-to-back assumptions.
//     MemReq may stay high across consecutive beats.
//   FLUSHED: one cycle with all valid bits cleared, then IDLE.
//  Flush (any state) has priority over everything:
//   - clear every valid bit, abandon any fill, drop MemReq next cycle, and enter FLUSHED.
//   - a memory ack arriving after the abandon is ignored.
//  ProgAddr changes during FILL are ignored; the fill always completes for the latched FillBase.
//  Reset: valid bits = 0, state = IDLE, cnt = 0, MemReq = 0, MemAddr = 0, InsCacheStall = 1.
//  The data and tag arrays are not reset.
//  After reset, the first fetch (ProgAddr = 0) always misses.
//  Reset in the middle of a fill behaves as Flush and also returns to IDLE directly.
//  cnt is $clog2(WORDS) bits and does not overflow, because it returns to 0 at the end of the line.
//  A line evicted by a conflicting tag is overwritten in place; it is invalid while its fill is in flight.
// STRUCTURE
//  Shared package icache_pkg:
//   - typedef enum logic [1:0] {IC_IDLE, IC_FILL, IC_FLUSHED} ic_state_t
//   - localparam functions for the TAG/IDX/OFF widths
//  One sub-module, ic_line_store: the data+tag+valid arrays.
//   - write port: index, word, data, set_valid
//   - read port: index
//   - clear-all input
//  The top level holds the FSM, address split and memory handshake.
// TESTING
//  1 Reset, ProgAddr=0 -> InsCacheStall=1; MemAddr 0,4,8,12 requested in order.
//    After the 4th ack, next cycle: stall=0 and Instruction = the word returned for 0x0.
//  2 Hit: ProgAddr=0x4, 0x8 after line 0 is filled -> stall=0 each cycle, MemReq stays 0.
//  3 Conflict: fetch 0x0, then 0x80 (same index, new tag) -> refill from 0x80..0x8C.
//    Fetching 0x0 again then misses again.
//  4 Slow memory: MemAck delayed 3 cycles per beat -> MemReq/MemAddr stable while waiting.
//    Total stall = 4*(3+1)+1 cycles.
//  5 Flush asserted on the 2nd fill beat -> MemReq=0 next cycle and all lines invalid.
//    A late ack is ignored; re-fetch of 0x0 restarts the fill at 0x0.
//  6 Reset asserted mid-fill, then released -> state IDLE, valid all 0.
//    ProgAddr=0x10 starts a fresh fill at 0x10.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-field width helpers for the RV32I instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {IC_IDLE, IC_FILL, IC_FLUSHED} ic_state_t;

  function automatic int ic_off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int ic_idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int ic_tag_w(input int dw, input int lines, input int words);
    return dw - $clog2(lines) - $clog2(words) - 2;
  endfunction

endpackage

// File: rtl/ic_line_store.sv
// Data, tag and valid arrays of the instruction cache: one write port, one read port, clear-all.
module ic_line_store
  import icache_pkg::*;
#(
  parameter int dataW = 32,
  parameter int LINES = 8,
  parameter int WORDS = 4,
  localparam int W = ic_off_w(WORDS),
  localparam int L = ic_idx_w(LINES),
  localparam int T = ic_tag_w(dataW, LINES, WORDS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr_all,
  input  logic             inv_en,
  input  logic             wr_en,
  input  logic             set_valid,
  input  logic [L-1:0]     wr_idx,
  input  logic [W-1:0]     wr_word,
  input  logic [dataW-1:0] wr_data,
  input  logic [T-1:0]     wr_tag,
  input  logic [L-1:0]     rd_idx,
  input  logic [W-1:0]     rd_word,
  output logic             rd_valid,
  output logic [T-1:0]     rd_tag,
  output logic [dataW-1:0] rd_data
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [T-1:0]     tag_q  [LINES];
  logic [T-1:0]     tag_d  [LINES];
  logic [dataW-1:0] data_q [LINES][WORDS];
  logic [dataW-1:0] data_d [LINES][WORDS];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (inv_en) valid_d[wr_idx] = 1'b0;
    if (wr_en) begin
      data_d[wr_idx][wr_word] = wr_data;
      if (set_valid) begin
        valid_d[wr_idx] = 1'b1;
        tag_d[wr_idx]   = wr_tag;
      end
    end
    // clear-all wins over a same-cycle line completion
    if (clr_all) valid_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clock) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_word];

endmodule

// File: rtl/ins_cache_r32i.sv
// Direct-mapped read-only instruction cache for the RV32I fetch stage.
// Combinational lookup; misses stall the PC and refill one line over a req/ack word port.
module ins_cache_r32i
  import icache_pkg::*;
#(
  parameter int dataW = 32,
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [dataW-1:0] ProgAddr,
  input  logic             Flush,
  output logic [dataW-1:0] Instruction,
  output logic             InsCacheStall,
  output logic             MemReq,
  output logic [dataW-1:0] MemAddr,
  input  logic             MemAck,
  input  logic [dataW-1:0] MemData
);

  localparam int W = ic_off_w(WORDS);
  localparam int L = ic_idx_w(LINES);
  localparam int T = ic_tag_w(dataW, LINES, WORDS);

  ic_state_t        state_q, state_d;
  logic [W-1:0]     cnt_q, cnt_d;
  logic [dataW-1:0] base_q, base_d;

  logic [W-1:0] a_word;
  logic [L-1:0] a_idx, f_idx, wr_idx;
  logic [T-1:0] a_tag, f_tag, rd_tag;
  logic         rd_valid, hit;
  logic [dataW-1:0] rd_data;
  logic         clr_all, inv_en, wr_en, set_valid;
  logic         unused_lo;

  assign a_word    = ProgAddr[W+1:2];
  assign a_idx     = ProgAddr[W+L+1:W+2];
  assign a_tag     = ProgAddr[dataW-1:W+L+2];
  assign f_idx     = base_q[W+L+1:W+2];
  assign f_tag     = base_q[dataW-1:W+L+2];
  assign unused_lo = ^ProgAddr[1:0];

  // a miss invalidates the requested line; fill beats target the latched line
  assign wr_idx = (state_q == IC_FILL) ? f_idx : a_idx;

  ic_line_store #(.dataW(dataW), .LINES(LINES), .WORDS(WORDS)) u_store (
    .clock    (clock),
    .reset    (reset),
    .clr_all  (clr_all),
    .inv_en   (inv_en),
    .wr_en    (wr_en),
    .set_valid(set_valid),
    .wr_idx   (wr_idx),
    .wr_word  (cnt_q),
    .wr_data  (MemData),
    .wr_tag   (f_tag),
    .rd_idx   (a_idx),
    .rd_word  (a_word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data)
  );

  assign hit           = rd_valid && (rd_tag == a_tag) && (state_q == IC_IDLE);
  assign Instruction   = hit ? rd_data : '0;
  assign InsCacheStall = !hit || reset || Flush;
  assign MemReq        = (state_q == IC_FILL);
  assign MemAddr       = MemReq ? (base_q + dataW'({cnt_q, 2'b00})) : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    clr_all   = 1'b0;
    inv_en    = 1'b0;
    wr_en     = 1'b0;
    set_valid = 1'b0;
    unique case (state_q)
      IC_IDLE: begin
        if (!hit) begin
          base_d  = {ProgAddr[dataW-1:W+2], {(W+2){1'b0}}};
          inv_en  = 1'b1;
          cnt_d   = '0;
          state_d = IC_FILL;
        end
      end
      IC_FILL: begin
        if (MemAck) begin
          wr_en = 1'b1;
          if (cnt_q == W'(WORDS-1)) begin
            set_valid = 1'b1;
            cnt_d     = '0;
            state_d   = IC_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      IC_FLUSHED: state_d = IC_IDLE;
      default:    state_d = IC_IDLE;
    endcase
    if (Flush) begin
      clr_all   = 1'b1;
      inv_en    = 1'b0;
      wr_en     = 1'b0;
      set_valid = 1'b0;
      cnt_d     = '0;
      state_d   = IC_FLUSHED;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IC_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

endmodule

// File: tb/tb_ins_cache_r32i.sv
// Self-checking bench for ins_cache_r32i: directed scenarios plus a randomized fetch stream
// checked against a line-level cache model and a random-content instruction memory.
module tb_ins_cache_r32i;

  logic        clock = 1'b0;
  logic        reset, Flush, MemAck;
  logic [31:0] ProgAddr, MemData;
  logic [31:0] Instruction, MemAddr;
  logic        InsCacheStall, MemReq;

  always #5 clock = ~clock;

  ins_cache_r32i dut (
    .clock        (clock),
    .reset        (reset),
    .ProgAddr     (ProgAddr),
    .Flush        (Flush),
    .Instruction  (Instruction),
    .InsCacheStall(InsCacheStall),
    .MemReq       (MemReq),
    .MemAddr      (MemAddr),
    .MemAck       (MemAck),
    .MemData      (MemData)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_arr [256];
  bit          mdl_valid [8];
  logic [24:0] mdl_tag [8];
  logic [31:0] req_q [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_arr[a[9:2]];
  endfunction

  // Drives one fetch until the cache stops stalling, acting as instruction memory with
  // dly idle cycles before each ack. Records requested addresses; performs no checks.
  task automatic do_fetch(input logic [31:0] addr, input int dly, output int stalls,
                          output logic [31:0] instr, output bit timeout, output bit unstable);
    int wait_n;
    logic [31:0] held;
    bit done;
    stalls = 0; instr = '0; timeout = 0; unstable = 0; wait_n = 0; held = '0; done = 0;
    req_q.delete();
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clock);
      ProgAddr = addr; MemAck = 1'b0; Flush = 1'b0;
      #1;
      if (!InsCacheStall) begin
        instr = Instruction;
        done  = 1;
      end else begin
        stalls++;
        if (MemReq) begin
          if (wait_n == 0) begin
            held = MemAddr;
            req_q.push_back(MemAddr);
          end else if (MemAddr !== held) unstable = 1;
          if (wait_n == dly) begin
            MemAck = 1'b1; MemData = mem_word(MemAddr); wait_n = 0;
          end else wait_n++;
        end else if (wait_n != 0) unstable = 1;
      end
    end
    if (!done) timeout = 1;
  endtask

  function automatic bit reqs_bad(input logic [31:0] base);
    if (req_q.size() != 4) return 1;
    for (int k = 0; k < 4; k++) if (req_q[k] !== base + 32'(4*k)) return 1;
    return 0;
  endfunction

  task automatic test_reset;
    reset = 1'b1; Flush = 1'b0; MemAck = 1'b0; MemData = '0; ProgAddr = '0;
    repeat (2) @(negedge clock);
    #1;
    n_tests++; if (InsCacheStall !== 1'b1) $display("FAIL reset_stall: got %b expected 1", InsCacheStall);
    else n_tests = n_tests; 
    if (InsCacheStall !== 1'b1) n_fail++;
    n_tests++; if (MemReq !== 1'b0) begin n_fail++; $display("FAIL reset_memreq: got %b expected 0", MemReq); end
    n_tests++; if (MemAddr !== 32'h0) begin n_fail++; $display("FAIL reset_memaddr: got %h expected 0", MemAddr); end
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_first_fill;
    int st; logic [31:0] ins; bit to, un;
    do_fetch(32'h0, 0, st, ins, to, un);
    n_tests++; if (to || st != 5) begin n_fail++; $display("FAIL first_fill_stalls: got %0d timeout %0d expected 5", st, to); end
    n_tests++; if (reqs_bad(32'h0)) begin n_fail++; $display("FAIL first_fill_addrs: got %0d requests expected 0,4,8,c", req_q.size()); end
    n_tests++; if (ins !== mem_word(32'h0)) begin n_fail++; $display("FAIL first_fill_instr: got %h expected %h", ins, mem_word(32'h0)); end
  endtask

  task automatic test_hit;
    int st; logic [31:0] ins; bit to, un;
    logic [31:0] addrs [3];
    addrs[0] = 32'h4; addrs[1] = 32'h8; addrs[2] = 32'hC;
    for (int i = 0; i < 3; i++) begin
      do_fetch(addrs[i], 0, st, ins, to, un);
      n_tests++; if (to || st != 0 || req_q.size() != 0) begin
        n_fail++; $display("FAIL hit_stall: addr %h got %0d stalls %0d requests expected 0", addrs[i], st, req_q.size());
      end
      n_tests++; if (ins !== mem_word(addrs[i])) begin
        n_fail++; $display("FAIL hit_instr: addr %h got %h expected %h", addrs[i], ins, mem_word(addrs[i]));
      end
    end
  endtask

  task automatic test_conflict;
    int st; logic [31:0] ins; bit to, un;
    do_fetch(32'h80, 0, st, ins, to, un);
    n_tests++; if (to || st != 5 || reqs_bad(32'h80)) begin n_fail++; $display("FAIL conflict_fill: got %0d stalls %0d requests expected 5 stalls from 80", st, req_q.size()); end
    n_tests++; if (ins !== mem_word(32'h80)) begin n_fail++; $display("FAIL conflict_instr: got %h expected %h", ins, mem_word(32'h80)); end
    do_fetch(32'h0, 0, st, ins, to, un);
    n_tests++; if (to || st != 5 || reqs_bad(32'h0)) begin n_fail++; $display("FAIL conflict_refetch: got %0d stalls expected 5", st); end
  endtask

  task automatic test_slow_mem;
    int st; logic [31:0] ins; bit to, un;
    do_fetch(32'h140, 3, st, ins, to, un);
    n_tests++; if (to || st != 17) begin n_fail++; $display("FAIL slow_stalls: got %0d timeout %0d expected 17", st, to); end
    n_tests++; if (un) begin n_fail++; $display("FAIL slow_stable: got unstable request expected stable"); end
    n_tests++; if (reqs_bad(32'h140) || ins !== mem_word(32'h140)) begin n_fail++; $display("FAIL slow_data: got %h expected %h", ins, mem_word(32'h140)); end
  endtask

  task automatic test_flush;
    int st; logic [31:0] ins; bit to, un;
    @(negedge clock); ProgAddr = 32'h20; MemAck = 1'b0; #1;
    n_tests++; if (InsCacheStall !== 1'b1 || MemReq !== 1'b0) begin n_fail++; $display("FAIL flush_miss: got stall %b req %b expected 1 0", InsCacheStall, MemReq); end
    @(negedge clock); #1;
    n_tests++; if (MemReq !== 1'b1 || MemAddr !== 32'h20) begin n_fail++; $display("FAIL flush_beat0: got req %b addr %h expected 1 20", MemReq, MemAddr); end
    MemAck = 1'b1; MemData = mem_word(32'h20);
    @(negedge clock); MemAck = 1'b0; #1;
    n_tests++; if (MemAddr !== 32'h24) begin n_fail++; $display("FAIL flush_beat1: got %h expected 24", MemAddr); end
    Flush = 1'b1; MemAck = 1'b1; MemData = mem_word(32'h24);
    @(negedge clock); Flush = 1'b0; MemAck = 1'b1; MemData = mem_word(32'h28); ProgAddr = 32'h0; #1;
    n_tests++; if (MemReq !== 1'b0 || InsCacheStall !== 1'b1) begin n_fail++; $display("FAIL flush_drop: got req %b stall %b expected 0 1", MemReq, InsCacheStall); end
    do_fetch(32'h0, 0, st, ins, to, un);
    n_tests++; if (to || st != 5 || reqs_bad(32'h0)) begin n_fail++; $display("FAIL flush_refill: got %0d stalls expected 5 from 0", st); end
    n_tests++; if (ins !== mem_word(32'h0)) begin n_fail++; $display("FAIL flush_instr: got %h expected %h", ins, mem_word(32'h0)); end
    do_fetch(32'h140, 0, st, ins, to, un);
    n_tests++; if (to || st != 5) begin n_fail++; $display("FAIL flush_invalid: got %0d stalls expected 5", st); end
  endtask

  task automatic test_reset_mid_fill;
    int st; logic [31:0] ins; bit to, un;
    @(negedge clock); ProgAddr = 32'h40; MemAck = 1'b0;
    @(negedge clock); #1; MemAck = 1'b1; MemData = mem_word(MemAddr);
    @(negedge clock); MemAck = 1'b0; reset = 1'b1; #1;
    n_tests++; if (InsCacheStall !== 1'b1) begin n_fail++; $display("FAIL rst_fill_stall: got %b expected 1", InsCacheStall); end
    @(posedge clock); #1 reset = 1'b0; ProgAddr = 32'h10;
    @(negedge clock); #1;
    n_tests++; if (MemReq !== 1'b0 || MemAddr !== 32'h0 || InsCacheStall !== 1'b1) begin
      n_fail++; $display("FAIL rst_fill_idle: got req %b addr %h stall %b expected 0 0 1", MemReq, MemAddr, InsCacheStall);
    end
    do_fetch(32'h10, 0, st, ins, to, un);
    n_tests++; if (to || st != 4 || reqs_bad(32'h10)) begin n_fail++; $display("FAIL rst_fill_new: got %0d stalls %0d requests expected 4 from 10", st, req_q.size()); end
    n_tests++; if (ins !== mem_word(32'h10)) begin n_fail++; $display("FAIL rst_fill_instr: got %h expected %h", ins, mem_word(32'h10)); end
    do_fetch(32'h0, 0, st, ins, to, un);
    n_tests++; if (to || st != 5) begin n_fail++; $display("FAIL rst_fill_invalid: got %0d stalls expected 5", st); end
  endtask

  task automatic test_random;
    int st, d, exp_st; logic [31:0] ins, a; bit to, un, exp_hit;
    logic [2:0] idx;
    for (int n = 0; n < 60; n++) begin
      if (n == 0 || $urandom_range(0, 7) == 0) begin
        @(negedge clock); Flush = 1'b1; MemAck = 1'b0; ProgAddr = 32'($urandom_range(0, 63)) << 2;
        @(negedge clock); Flush = 1'b0;
        for (int i = 0; i < 8; i++) mdl_valid[i] = 0;
      end
      a = 32'($urandom_range(0, 63)) << 2;
      d = $urandom_range(0, 2);
      idx = a[6:4];
      exp_hit = mdl_valid[idx] && (mdl_tag[idx] == a[31:7]);
      exp_st = exp_hit ? 0 : 4 * (d + 1) + 1;
      do_fetch(a, d, st, ins, to, un);
      n_tests++; if (to || st != exp_st) begin n_fail++; $display("FAIL rand_stalls: addr %h got %0d expected %0d", a, st, exp_st); end
      n_tests++; if (ins !== mem_word(a)) begin n_fail++; $display("FAIL rand_instr: addr %h got %h expected %h", a, ins, mem_word(a)); end
      if (!exp_hit) begin
        n_tests++; if (un || reqs_bad({a[31:4], 4'h0})) begin n_fail++; $display("FAIL rand_reqs: addr %h got %0d requests unstable %0d", a, req_q.size(), un); end
        mdl_valid[idx] = 1; mdl_tag[idx] = a[31:7];
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
    test_reset;
    test_first_fill;
    test_hit;
    test_conflict;
    test_slow_mem;
    test_flush;
    test_reset_mid_fill;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
